mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Multi-cycle data-memory access sequencer between the main decoder's memory controls (memReq, memWrite, funct3) and a variable-latency req/ack data bus. Builds the byte-lane request from the effective address and access size, and holds the core stalled until the bus acknowledges. It then returns aligned, sign/zero-extended load data for writeback. It also flags misaligned accesses and bus timeouts.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 255, max wait cycles in REQ before fault (1..2^CNT_W-1)
CNT_W, 8, wait-counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_memReq  in  1  access requested by current instruction (held while o_stall=1)
i_memWrite  in  1  1=store, 0=load
i_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] 1=zero-extend load
i_addr  in  XLEN  effective byte address
i_wdata  in  XLEN  store data, LSB-justified
o_stall  out  1  freeze pipeline
o_rdata  out  XLEN  extended load data, valid when o_done=1 and load
o_done  out  1  one-cycle completion pulse
o_misaligned  out  1  one-cycle pulse: misaligned or illegal size, no bus access
o_busFault  out  1  one-cycle pulse: timeout or i_busErr
o_busReq  out  1  bus request, held until ack
o_busWrite  out  1  bus write
o_busAddr  out  XLEN  word-aligned address (i_addr[1:0] forced 00)
o_busWdata  out  XLEN  lane-shifted store data
o_busBe  out  4  byte enables
i_busAck  in  1  bus completes transfer this cycle
i_busErr  in  1  bus error, qualified by i_busAck
i_busRdata  in  XLEN  raw word, valid with i_busAck

Behaviour:
- Reset (async, any state): state=IDLE; counter=0; o_busReq, o_busWrite, o_done, o_misaligned, o_busFault=0; o_busAddr, o_busWdata, o_rdata=0; o_busBe=0000.
- States: IDLE, REQ, DONE, EXC.
- IDLE: o_stall = i_memReq (combinational). If i_memReq and legal+aligned: register bus address, data, byte enables and write bit, set o_busReq, clear counter, go to REQ. If i_memReq and illegal/misaligned: go to EXC, no bus activity.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always illegal.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111. Store data shifted left by 8*addr[1:0]; unused lanes are don't-care.
- REQ: o_stall=1; bus outputs held stable.
  - If i_busAck: drop o_busReq next cycle. If i_busErr, go to EXC with fault; else capture i_busRdata, go to DONE.
  - Otherwise counter++. When counter reaches TIMEOUT without ack: drop o_busReq, go to EXC with fault.
- DONE: o_stall=0, o_done=1, o_rdata valid for loads; next state IDLE. The pipeline advances at the end of this cycle, so the same instruction is never re-issued.
- Load extraction: shift captured word right by 8*addr[1:0]. Byte/half are sign-extended when funct3[2]=0, zero-extended when 1. Stores leave o_rdata unchanged.
- EXC: o_stall=0; exactly one of o_misaligned / o_busFault =1; next state IDLE.
- Latency: zero-wait access issues in cycle 0 (IDLE), acks in cycle 1 (REQ), completes in cycle 2 (DONE). Stall lasts 2 cycles plus wait cycles.
- Ack arriving in IDLE, DONE or EXC is ignored.
- Reset mid-REQ drops o_busReq immediately; the bus must tolerate the abandoned request.

Decomposition:
- Shared package: state enum; size encodings SZ_B/SZ_H/SZ_W; TIMEOUT default.
- Sub-module: mem_lane_align, purely combinational. It computes byte enables, store shift, load extract/extend and the misaligned flag.
- The FSM and counter stay in mem_access_ctrl.

Test Plan:
- LW addr 0x100, ack in first REQ cycle with rdata 0xDEADBEEF -> o_busBe=1111, o_busAddr=0x100, stall 2 cycles, o_done with o_rdata=0xDEADBEEF.
- SB addr 0x1003, wdata 0x000000A5, ack after 3 waits -> o_busBe=1000, o_busWdata[31:24]=0xA5, o_busWrite=1, o_busReq held 4 cycles, o_done pulse.
- LH addr 0x2002 funct3=001, rdata 0x8001_1234 -> o_rdata=0xFFFF8001; repeat with funct3=101 -> 0x00008001.
- LW addr 0x3001 -> o_misaligned pulse one cycle after request, o_busReq never asserted, stall 1 cycle; funct3=011 gives the same result.
- No ack, TIMEOUT=4 -> o_busReq high 5 cycles, then o_busFault pulse, return to IDLE; ack with i_busErr=1 -> o_busFault, no o_done.
- Assert i_rst_n=0 during REQ -> o_busReq and o_stall drop asynchronously; after release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the data-memory access sequencer.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    EXC  = 2'b11
  } mac_state_e;

  // Access size as carried in funct3[1:0]
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } mac_size_e;

  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Req/ack data-bus bundle between the access sequencer (master) and memory (slave).
interface mem_access_ctrl_if #(
  parameter int XLEN = 32
);

  logic            busReq;
  logic            busWrite;
  logic [XLEN-1:0] busAddr;
  logic [XLEN-1:0] busWdata;
  logic [3:0]      busBe;
  logic            busAck;
  logic            busErr;
  logic [XLEN-1:0] busRdata;

  modport master (
    output busReq, busWrite, busAddr, busWdata, busBe,
    input  busAck, busErr, busRdata
  );

  modport slave (
    input  busReq, busWrite, busAddr, busWdata, busBe,
    output busAck, busErr, busRdata
  );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: byte enables, store shift, load extract/extend, alignment check.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offs_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rawRdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdataShifted_o,
  output logic [XLEN-1:0] rdataExt_o,
  output logic            misaligned_o
);

  mac_size_e       size;
  logic [4:0]      shAmt;
  logic [XLEN-1:0] loaded;
  logic            signExt;

  assign size    = mac_size_e'(funct3_i[1:0]);
  assign shAmt   = {offs_i, 3'b000};
  assign signExt = ~funct3_i[2];

  // Decode lanes and extension from size and the low address bits
  always_comb begin
    be_o           = 4'b0000;
    misaligned_o   = 1'b0;
    wdataShifted_o = wdata_i << shAmt;
    loaded         = rawRdata_i >> shAmt;
    rdataExt_o     = loaded;
    unique case (size)
      SZ_B: begin
        be_o       = 4'b0001 << offs_i;
        rdataExt_o = {{(XLEN-8){signExt & loaded[7]}}, loaded[7:0]};
      end
      SZ_H: begin
        be_o         = 4'b0011 << offs_i;
        misaligned_o = offs_i[0];
        rdataExt_o   = {{(XLEN-16){signExt & loaded[15]}}, loaded[15:0]};
      end
      SZ_W: begin
        be_o         = 4'b1111;
        misaligned_o = |offs_i;
      end
      SZ_X: begin
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: issues one bus transfer per access and stalls until it ends.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_memReq,
  input  logic            i_memWrite,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_done,
  output logic            o_misaligned,
  output logic            o_busFault,
  mem_access_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mac_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            busReq_q;
  logic            busWrite_q;
  logic [XLEN-1:0] busAddr_q;
  logic [XLEN-1:0] busWdata_q;
  logic [3:0]      busBe_q;
  logic [XLEN-1:0] rdata_q;
  logic            done_q;
  logic            mis_q;
  logic            fault_q;
  logic [1:0]      offs_q;
  logic [2:0]      funct3_q;

  logic [2:0]      laneFunct3_d;
  logic [1:0]      laneOffs_d;
  logic [3:0]      laneBe;
  logic [XLEN-1:0] laneWdata;
  logic [XLEN-1:0] laneRdata;
  logic            laneMis;

  // Incoming request decides lanes while idle; the latched access decides load extraction
  assign laneFunct3_d = (state_q == IDLE) ? i_funct3    : funct3_q;
  assign laneOffs_d   = (state_q == IDLE) ? i_addr[1:0] : offs_q;

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .funct3_i       (laneFunct3_d),
    .offs_i         (laneOffs_d),
    .wdata_i        (i_wdata),
    .rawRdata_i     (bus.busRdata),
    .be_o           (laneBe),
    .wdataShifted_o (laneWdata),
    .rdataExt_o     (laneRdata),
    .misaligned_o   (laneMis)
  );

  // Stall is combinational so the pipeline freezes in the same cycle the request shows up
  always_comb begin
    o_stall = 1'b0;
    unique case (state_q)
      IDLE:      o_stall = i_memReq;
      REQ:       o_stall = 1'b1;
      DONE, EXC: o_stall = 1'b0;
    endcase
    o_stall = o_stall & i_rst_n;
  end

  // Sequencer FSM with wait counter and registered bus/status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busReq_q   <= 1'b0;
      busWrite_q <= 1'b0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      busBe_q    <= 4'b0000;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      fault_q    <= 1'b0;
      offs_q     <= 2'b00;
      funct3_q   <= 3'b000;
    end else begin
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_memReq) begin
            if (laneMis) begin
              mis_q   <= 1'b1;
              state_q <= EXC;
            end else begin
              busAddr_q  <= {i_addr[XLEN-1:2], 2'b00};
              busWdata_q <= laneWdata;
              busBe_q    <= laneBe;
              busWrite_q <= i_memWrite;
              busReq_q   <= 1'b1;
              cnt_q      <= '0;
              offs_q     <= i_addr[1:0];
              funct3_q   <= i_funct3;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.busAck) begin
            busReq_q <= 1'b0;
            if (bus.busErr) begin
              fault_q <= 1'b1;
              state_q <= EXC;
            end else begin
              if (!busWrite_q) begin
                rdata_q <= laneRdata;
              end
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (cnt_q == TIMEOUT_CNT) begin
            busReq_q <= 1'b0;
            fault_q  <= 1'b1;
            state_q  <= EXC;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE, EXC: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busReq   = busReq_q;
  assign bus.busWrite = busWrite_q;
  assign bus.busAddr  = busAddr_q;
  assign bus.busWdata = busWdata_q;
  assign bus.busBe    = busBe_q;
  assign o_rdata      = rdata_q;
  assign o_done       = done_q;
  assign o_misaligned = mis_q;
  assign o_busFault   = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, reset-in-flight sequence, random accesses.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  typedef enum int {K_DONE, K_MIS, K_FAULT} kind_e;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] raw;
    kind_e       kind;
    int          reqCycles;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] rdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        memReq;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        misaligned;
  logic        busFault;

  int nCompared;
  int nMismatched;
  logic [31:0] mdlRdata;

  mem_access_ctrl_if #(.XLEN(32)) bus ();

  mem_access_ctrl #(.XLEN(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_memReq     (memReq),
    .i_memWrite   (memWrite),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_stall      (stall),
    .o_rdata      (rdata),
    .o_done       (done),
    .o_misaligned (misaligned),
    .o_busFault   (busFault),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference model: byte-list view of the access
  function automatic int nBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic mdlMis(input logic [2:0] f3, input logic [31:0] a);
    int n = nBytes(f3);
    return (f3[1:0] == 2'b11) || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] mdlBe(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int off = int'(a[1:0]);
    for (int i = 0; i < nBytes(f3); i++) if (off + i < 4) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] mdlWlane(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r = '0;
    int off = int'(a[1:0]);
    for (int i = 0; i < nBytes(f3); i++) if (off + i < 4) r[8*(off+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
    longint v = 0;
    int off = int'(a[1:0]);
    int n = nBytes(f3);
    for (int i = 0; i < n; i++) v = v + (longint'(raw[8*(off+i) +: 8]) << (8*i));
    if (!f3[2] && n < 4 && ((v >> (8*n - 1)) & 1) == 1) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  function automatic vec_t mdlVec(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input int waits, input logic err,
                                  input logic [31:0] raw);
    vec_t v;
    v = '{w, f3, a, wd, waits, err, raw, K_DONE, 0, 4'h0, 32'h0, 32'h0};
    if (mdlMis(f3, a)) begin
      v.kind = K_MIS;
    end else begin
      v.be        = mdlBe(f3, a);
      v.wlane     = mdlWlane(f3, a, wd);
      v.reqCycles = (waits > TO) ? TO + 1 : waits + 1;
      v.kind      = (waits > TO || err) ? K_FAULT : K_DONE;
      if (v.kind == K_DONE && !w) v.rdata = mdlLoad(f3, a, raw);
    end
    return v;
  endfunction

  // One access from issue to the cycle after completion; entered and left at posedge+1
  task automatic applyStimulus(input vec_t v);
    int reqGood = 0;
    logic [31:0] expR;
    expR = (v.kind == K_DONE && !v.write) ? v.rdata : mdlRdata;
    memReq = 1'b1; memWrite = v.write; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    bus.busAck = 1'b0; bus.busErr = 1'b0;
    @(negedge clk);
    checkOutput("stall_issue", 32'(stall), 32'd1);
    checkOutput("req_in_idle", 32'(bus.busReq), 32'd0);
    for (int c = 0; c < v.reqCycles; c++) begin
      @(posedge clk); #1;
      if (c == v.waits && v.waits <= TO) begin
        bus.busAck = 1'b1; bus.busErr = v.err; bus.busRdata = v.raw;
      end else begin
        bus.busAck = 1'b0; bus.busErr = 1'b0; bus.busRdata = $urandom;
      end
      @(negedge clk);
      if (bus.busReq && stall) reqGood++;
      if (c == 0) begin
        checkOutput("busAddr", bus.busAddr, {v.addr[31:2], 2'b00});
        checkOutput("busBe", 32'(bus.busBe), 32'(v.be));
        checkOutput("busWrite", 32'(bus.busWrite), 32'(v.write));
        if (v.write) begin
          for (int b = 0; b < 4; b++)
            if (v.be[b]) checkOutput("busWdata_lane", 32'(bus.busWdata[8*b +: 8]), 32'(v.wlane[8*b +: 8]));
        end
      end
    end
    checkOutput("req_cycles", 32'(reqGood), 32'(v.reqCycles));
    @(posedge clk); #1;
    bus.busAck = 1'b0; bus.busErr = 1'b0;
    memReq = 1'b0;
    @(negedge clk);
    checkOutput("done", 32'(done), 32'(v.kind == K_DONE));
    checkOutput("misaligned", 32'(misaligned), 32'(v.kind == K_MIS));
    checkOutput("busFault", 32'(busFault), 32'(v.kind == K_FAULT));
    checkOutput("stall_end", 32'(stall), 32'd0);
    checkOutput("req_end", 32'(bus.busReq), 32'd0);
    checkOutput("rdata", rdata, expR);
    mdlRdata = expR;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("pulses_clear", {29'd0, done, misaligned, busFault}, 32'd0);
    checkOutput("rdata_hold", rdata, expR);
    @(posedge clk); #1;
  endtask

  vec_t table_v[12];

  initial begin
    nCompared = 0; nMismatched = 0; mdlRdata = 32'h0;
    table_v[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 1'b0, 32'hDEAD_BEEF, K_DONE,  1, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    table_v[1]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 3, 1'b0, 32'h0,        K_DONE,  4, 4'b1000, 32'hA500_0000, 32'h0};
    table_v[2]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        1, 1'b0, 32'h8001_1234, K_DONE,  2, 4'b1100, 32'h0,        32'hFFFF_8001};
    table_v[3]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        0, 1'b0, 32'h8001_1234, K_DONE,  1, 4'b1100, 32'h0,        32'h0000_8001};
    table_v[4]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,        0, 1'b0, 32'h0,        K_MIS,   0, 4'b0000, 32'h0,        32'h0};
    table_v[5]  = '{1'b0, 3'b011, 32'h0000_3001, 32'h0,        0, 1'b0, 32'h0,        K_MIS,   0, 4'b0000, 32'h0,        32'h0};
    table_v[6]  = '{1'b0, 3'b010, 32'h0000_4000, 32'h0,        9, 1'b0, 32'h0,        K_FAULT, 5, 4'b1111, 32'h0,        32'h0};
    table_v[7]  = '{1'b0, 3'b010, 32'h0000_5000, 32'h0,        1, 1'b1, 32'h1111_2222, K_FAULT, 2, 4'b1111, 32'h0,        32'h0};
    table_v[8]  = '{1'b0, 3'b000, 32'h0000_6001, 32'h0,        0, 1'b0, 32'h0000_8000, K_DONE,  1, 4'b0010, 32'h0,        32'hFFFF_FF80};
    table_v[9]  = '{1'b1, 3'b001, 32'h0000_7002, 32'h0000_1234, 2, 1'b0, 32'h0,        K_DONE,  3, 4'b1100, 32'h1234_0000, 32'h0};
    table_v[10] = '{1'b0, 3'b100, 32'h0000_6003, 32'h0,        0, 1'b0, 32'hF000_0000, K_DONE,  1, 4'b1000, 32'h0,        32'h0000_00F0};
    table_v[11] = '{1'b1, 3'b010, 32'h0000_8000, 32'hCAFE_F00D, 0, 1'b0, 32'h0,        K_DONE,  1, 4'b1111, 32'hCAFE_F00D, 32'h0};

    rst_n = 1'b0; memReq = 1'b0; memWrite = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    bus.busAck = 1'b0; bus.busErr = 1'b0; bus.busRdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_busReq", 32'(bus.busReq), 32'd0);
    checkOutput("rst_busBe", 32'(bus.busBe), 32'd0);
    checkOutput("rst_busAddr", bus.busAddr, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_pulses", {29'd0, done, misaligned, busFault}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int i = 0; i < 12; i++) applyStimulus(table_v[i]);

    $display("[TB] reset during REQ");
    memReq = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h0000_0900;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midreq_busReq", 32'(bus.busReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busReq", 32'(bus.busReq), 32'd0);
    checkOutput("async_stall", 32'(stall), 32'd0);
    checkOutput("async_rdata", rdata, 32'd0);
    mdlRdata = 32'h0;
    @(posedge clk); #1;
    memReq = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(table_v[0]);

    $display("[TB] random accesses");
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      applyStimulus(mdlVec(1'($urandom), f3, a, $urandom, $urandom_range(0, TO + 2),
                           ($urandom_range(0, 7) == 0), $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
